irq_controller: RTL
===================

# irq_controller

Machine-mode interrupt controller sitting between the external interrupt sources and the core's CSR controller. It masks pending requests with `mie`, selects one by fixed priority, raises the trap request and `mcause` value, holds off further interrupts until the handler executes `mret`, then acknowledges the served source. Nesting is not supported: one interrupt is in service at a time.

## Interface
Parameters:
- `IRQ_NUM`, default 16: number of interrupt sources, legal range 1..16. Source `i` maps to `mie` bit `i` and cause code `16+i`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `irq_req_i`  in  `IRQ_NUM`  level-sensitive interrupt requests; bit 0 has the highest priority.
- `mie_i`  in  32  current `mie` CSR value; only bits `[IRQ_NUM-1:0]` are used.
- `exception_i`  in  1  the core is taking a synchronous exception this cycle.
- `stall_i`  in  1  the core cannot take a trap this cycle.
- `mret_i`  in  1  `mret` retires this cycle.
- `irq_o`  out  1  trap request to the core and CSR controller (drives `trap_i`).
- `irq_cause_o`  out  32  `mcause` value for the trap (drives `mcause_i`).
- `irq_ack_o`  out  `IRQ_NUM`  one-hot acknowledge to the served source.

## Operation
- Pending vector: `irq_req_i & mie_i[IRQ_NUM-1:0]`. The selected index is the lowest set bit.
- States:
  - IDLE
    - If the pending vector is non-zero and `exception_i` = 0, latch the index and go to TRAP.
    - Otherwise stay in IDLE.
  - TRAP
    - `irq_o` = 1.
    - If `stall_i` = 0, the trap is taken this cycle; go to SERVICE.
    - If `stall_i` = 1, stay in TRAP.
  - SERVICE
    - Wait for `mret_i` = 1, then go to ACK.
  - ACK
    - `irq_ack_o` = one-hot of the latched index for this single cycle.
    - Go to IDLE unconditionally.
- `irq_cause_o` = `32'h8000_0010 + index`. The value is loaded when the index is latched and held until the next latch. It is not cleared in IDLE.
- The latched index is never re-evaluated after leaving IDLE. A source that drops its request, or whose `mie` bit is cleared, during TRAP or SERVICE is still served and acknowledged.
- `exception_i` in TRAP does not cancel the request. The core gives an exception priority by keeping `stall_i` high.
- `mret_i` is ignored in IDLE, TRAP and ACK.
- `exception_i`, `stall_i` and `mret_i` have no effect on state in ACK.
- When `IRQ_NUM` = 1, the index is 1 bit wide and is always 0.

## Timing
- Reset (asynchronous, `rst_ni` = 0):
  - State = IDLE, index = 0.
  - `irq_o` = 0, `irq_cause_o` = 0, `irq_ack_o` = 0.
- Reset asserted mid-operation returns to IDLE immediately. No acknowledge is issued.
- All outputs are decoded from registered state only, so there is no combinational path from any input to any output.
- Request latency: pending sampled at edge k gives `irq_o` = 1 from cycle k+1.
- `irq_o` stays high until the first cycle with `stall_i` = 0, inclusive. In that cycle the trap is taken and `mepc`/`mcause` are written.
- `irq_cause_o` is stable for the whole time `irq_o` is high.
- `mret_i` at edge m gives `irq_ack_o` high during cycle m+1.
- The earliest next `irq_o` is cycle m+2, and only if a request is pending at edge m+1.
- A source that stays asserted through its ACK cycle will re-trigger. Sources must drop their request on `irq_ack_o`.

## Structure
- `irq_pkg` holds:
  - the state enum `irq_state_t` (IDLE, TRAP, SERVICE, ACK);
  - `IRQ_CAUSE_BASE` = `32'h8000_0010`;
  - `IRQ_MAX` = 16.
- One sub-module: `irq_priority_encoder`.
  - Parameterised by `IRQ_NUM`.
  - Input: pending vector. Outputs: `valid_o` and `index_o` of width `$clog2` of `IRQ_NUM`, minimum 1.
  - Purely combinational.
- The top level holds the FSM, the index/cause register and the acknowledge decode.

## Test plan
- Single source:
  - Stimulus: `mie_i` = `32'h0000_0008`, `irq_req_i[3]` pulsed, `stall_i` = 0.
  - Response: `irq_o` high exactly 1 cycle with `irq_cause_o` = `32'h8000_0013`. Then `mret_i` → `irq_ack_o` = `16'h0008` for 1 cycle, one cycle later.
- Priority and masking:
  - Stimulus: `irq_req_i` = `16'h0024`, `mie_i` = `32'h0000_0020`.
  - Response: cause `32'h8000_0015`. With `mie_i` = `32'h0000_FFFF` instead, cause `32'h8000_0012`.
- Stall and exception:
  - Stimulus: `exception_i` = 1 while a request is pending in IDLE.
  - Response: no `irq_o`.
  - Stimulus: `stall_i` = 1 for 3 cycles during TRAP.
  - Response: `irq_o` high for 4 cycles, cause constant.
- No nesting:
  - Stimulus: `irq_req_i[0]` raised while source 5 is in SERVICE.
  - Response: no `irq_o` until 2 cycles after `mret_i`, then cause `32'h8000_0010`.
- Request withdrawal:
  - Stimulus: source drops its request and its `mie` bit is cleared in SERVICE.
  - Response: `irq_ack_o` still issued for that source on `mret_i`.
  - Stimulus: stray `mret_i` in IDLE.
  - Response: no `irq_ack_o`.
- Reset:
  - Stimulus: `rst_ni` pulsed low in SERVICE.
  - Response: all outputs 0 asynchronously, no ack. A pending request after release gives `irq_o` 1 cycle after the first sampling edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRAP,
    SERVICE,
    ACK
  } irq_state_t;

  localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;
  localparam int          IRQ_MAX        = 16;

  // Index width for n sources; a single source still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Request/trap/acknowledge bundle between interrupt sources, the core and the controller.
interface irq_controller_if #(
  parameter int IRQ_NUM = 16
);

  logic [IRQ_NUM-1:0] irq_req_i;
  logic [31:0]        mie_i;
  logic               exception_i;
  logic               stall_i;
  logic               mret_i;
  logic               irq_o;
  logic [31:0]        irq_cause_o;
  logic [IRQ_NUM-1:0] irq_ack_o;

  modport master (
    output irq_req_i, mie_i, exception_i, stall_i, mret_i,
    input  irq_o, irq_cause_o, irq_ack_o
  );

  modport slave (
    input  irq_req_i, mie_i, exception_i, stall_i, mret_i,
    output irq_o, irq_cause_o, irq_ack_o
  );

endinterface

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports the lowest set bit of the pending vector.
module irq_priority_encoder
  import irq_pkg::*;
#(
  parameter  int IRQ_NUM = 16,
  localparam int IDX_W   = idx_width(IRQ_NUM)
) (
  input  logic [IRQ_NUM-1:0] pending_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   index_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid_o = |pending_i;
    index_o = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (pending_i[i]) begin
        index_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Non-nesting interrupt controller: mask, prioritise, raise the trap, wait for mret, acknowledge.
module irq_controller
  import irq_pkg::*;
#(
  parameter int IRQ_NUM = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  irq_controller_if.slave  bus
);

  localparam int IDX_W = idx_width(IRQ_NUM);

  if (IRQ_NUM < 1 || IRQ_NUM > IRQ_MAX) begin : g_bad_param
    $error("irq_controller: IRQ_NUM out of range");
  end

  irq_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        cause_q, cause_d;
  logic [IRQ_NUM-1:0] pending;
  logic               pend_valid;
  logic [IDX_W-1:0]   pend_idx;
  logic [IRQ_NUM-1:0] ack;
  logic               unused_mie;

  assign pending    = bus.irq_req_i & bus.mie_i[IRQ_NUM-1:0];
  assign unused_mie = ^bus.mie_i[31:IRQ_NUM];

  irq_priority_encoder #(
    .IRQ_NUM (IRQ_NUM)
  ) u_prio (
    .pending_i (pending),
    .valid_o   (pend_valid),
    .index_o   (pend_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cause_q <= cause_d;
    end
  end

  // The index and cause are captured only on leaving IDLE and never revisited until the next trap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (pend_valid && !bus.exception_i) begin
          idx_d   = pend_idx;
          cause_d = IRQ_CAUSE_BASE + 32'(pend_idx);
          state_d = TRAP;
        end
      end
      TRAP: begin
        if (!bus.stall_i) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.mret_i) begin
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < IRQ_NUM; gi++) begin : g_ack
    assign ack[gi] = (state_q == ACK) && (idx_q == IDX_W'(gi));
  end

  assign bus.irq_o       = (state_q == TRAP);
  assign bus.irq_cause_o = cause_q;
  assign bus.irq_ack_o   = ack;

endmodule
